// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I pipeline: branch predictor counter encoding and table entry layout.
package rv32i_pkg;

  localparam int unsigned BP_TAG_W = 8;

  typedef enum logic [1:0] {
    BP_SNT = 2'd0,
    BP_WNT = 2'd1,
    BP_WT  = 2'd2,
    BP_ST  = 2'd3
  } bp_ctr_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    bp_ctr_t             ctr;
    logic [31:0]         target;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state: taken counts up to ST, not-taken counts down to SNT.
module bp_sat_counter
  import rv32i_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tag/target table and mispredict redirect.
// Optional BP_STATS_EN adds saturating resolved-branch and mispredict counters.
module branch_predictor
  import rv32i_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  // Flop array so reset can clear every entry in one cycle.
  bp_entry_t bp_table [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;
  bp_entry_t        if_entry;
  bp_entry_t        ex_entry;
  logic             if_hit;
  logic             ex_hit;
  logic             upd_en;
  logic             alias_clr;
  logic [1:0]       ctr_next;
  bp_ctr_t          alloc_ctr;

  assign if_idx   = if_pc[IDX_W+1:2];
  assign if_tag   = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx   = ex_pc[IDX_W+1:2];
  assign ex_tag   = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign if_entry = bp_table[if_idx];
  assign ex_entry = bp_table[ex_idx];

  // Fetch-side lookup; sees pre-update contents when indices collide.
  assign if_hit      = if_valid & if_entry.valid & (if_entry.tag == BP_TAG_W'(if_tag));
  assign pred_taken  = if_hit & if_entry.ctr[1];
  assign pred_target = pred_taken ? if_entry.target : if_pc + 32'd4;

  assign ex_hit    = ex_entry.valid & (ex_entry.tag == BP_TAG_W'(ex_tag));
  assign upd_en    = ex_valid & ex_is_branch;
  assign alias_clr = ex_valid & ~ex_is_branch & ex_pred_taken;

  assign mispredict = ex_valid &
                      ((ex_is_branch & ((ex_taken != ex_pred_taken) |
                                        (ex_taken & (ex_target != ex_pred_target)))) |
                       (~ex_is_branch & ex_pred_taken));
  assign redirect_pc = (ex_is_branch & ex_taken) ? ex_target : ex_pc + 32'd4;

  bp_sat_counter u_sat_counter (
    .ctr      (ex_entry.ctr),
    .taken    (ex_taken),
    .ctr_next (ctr_next)
  );

  always_comb begin
    alloc_ctr = BP_WNT;
    if (ex_taken) alloc_ctr = BP_WT;
  end

  // Table training: hit adjusts counter, miss allocates, non-branch predicted taken invalidates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        bp_table[i] <= '{valid: 1'b0, tag: '0, ctr: BP_WNT, target: '0};
      end
    end else if (upd_en) begin
      if (ex_hit) begin
        bp_table[ex_idx].ctr <= bp_ctr_t'(ctr_next);
        if (ex_taken) bp_table[ex_idx].target <= ex_target;
      end else begin
        bp_table[ex_idx] <= '{valid: 1'b1, tag: BP_TAG_W'(ex_tag), ctr: alloc_ctr,
                              target: ex_target};
      end
    end else if (alias_clr) begin
      bp_table[ex_idx].valid <= 1'b0;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_en && stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
      if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{if_pc, ex_pc, ex_entry.target};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test-plan scenarios plus randomized traffic
// against a table model built from the predictor's architectural rules.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one record per table slot.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [31:0] m_sb;
  logic [31:0] m_sm;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int m_tagof(logic [31:0] pc);
    return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
  endfunction

  function automatic logic exp_taken(logic v, logic [31:0] pc);
    int i = m_idx(pc);
    return v && m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(logic v, logic [31:0] pc);
    return exp_taken(v, pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic logic exp_misp();
    if (!ex_valid) return 1'b0;
    if (ex_is_branch)
      return (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
    return ex_pred_taken;
  endfunction

  function automatic logic [31:0] exp_redir();
    return (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_sb = '0;
    m_sm = '0;
  endtask

  task automatic model_apply();
    int i = m_idx(ex_pc);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (exp_misp() && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
    if (ex_valid && ex_is_branch) begin
      if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 1;
      if (m_valid[i] && m_tag[i] == m_tagof(ex_pc)) begin
        m_ctr[i] = ex_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                            : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (ex_taken) m_tgt[i] = ex_target;
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(ex_pc);
        m_ctr[i]   = ex_taken ? 2 : 1;
        m_tgt[i]   = ex_target;
      end
    end else if (ex_valid && ex_pred_taken) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // Advance one clock, updating the model with what the DUT sampled; returns at negedge.
  task automatic tick();
    @(posedge clk);
    model_apply();
    @(negedge clk);
  endtask

  task automatic set_ex(logic v, logic br, logic [31:0] pc, logic tk, logic [31:0] tgt,
                        logic ptk, logic [31:0] ptgt);
    ex_valid       = v;
    ex_is_branch   = br;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic resolve(logic [31:0] pc, logic tk, logic [31:0] tgt);
    set_ex(1'b1, 1'b1, pc, tk, tgt, exp_taken(1'b1, pc), exp_target(1'b1, pc));
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_valid = 1'b1;
    if_pc = 32'h100;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken);
    end
    n_checks++;
    if (pred_target !== 32'h104) begin
      n_fail++; $display("FAIL reset_pred_target got=%h exp=00000104", pred_target);
    end
`ifdef BP_STATS_EN
    n_checks++;
    if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
      n_fail++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
    end
`endif
  endtask

  task automatic test_train_taken();
    if_pc = 32'h100;
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    n_checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      n_fail++; $display("FAIL train_misp got=%b/%h exp=1/00000080", mispredict, redirect_pc);
    end
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_fail++; $display("FAIL train_lookup got=%b/%h exp=1/00000080", pred_taken, pred_target);
    end
  endtask

  task automatic test_saturation();
    if_pc = 32'h100;
    for (int k = 0; k < 3; k++) resolve(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b0, 32'h80);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_fail++; $display("FAIL sat_st_to_wt got=%b/%h exp=1/00000080", pred_taken, pred_target);
    end
    resolve(32'h100, 1'b0, 32'h80);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_fail++; $display("FAIL sat_wt_to_wnt got=%b/%h exp=0/00000104", pred_taken, pred_target);
    end
  endtask

  task automatic test_alias();
    resolve(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b1, 32'h80);
    if_pc = 32'h100 + ENTRIES * 4;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== if_pc + 32'd4) begin
      n_fail++; $display("FAIL alias_tag_miss got=%b/%h exp=0/%h", pred_taken, pred_target, if_pc + 4);
    end
    if_pc = 32'h100;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL alias_trained got=%b exp=1", pred_taken);
    end
    set_ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    n_checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin
      n_fail++; $display("FAIL alias_misp got=%b/%h exp=1/00000104", mispredict, redirect_pc);
    end
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL alias_invalidated got=%b exp=0", pred_taken);
    end
  endtask

  task automatic test_same_cycle();
    if_pc = 32'h100;
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_fail++; $display("FAIL same_cycle_old got=%b/%h exp=0/00000104", pred_taken, pred_target);
    end
    tick();
    set_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h300, 1'b1, 32'h300);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      n_fail++; $display("FAIL same_cycle_old2 got=%b/%h exp=1/00000300", pred_taken, pred_target);
    end
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_new got=%b exp=0", pred_taken);
    end
  endtask

  task automatic test_reset_update();
    resolve(32'h100, 1'b1, 32'h80);
    if_pc = 32'h100;
    rst_n = 1'b0;
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();
    rst_n = 1'b1;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_fail++; $display("FAIL reset_wins got=%b/%h exp=0/00000104", pred_taken, pred_target);
    end
`ifdef BP_STATS_EN
    n_checks++;
    if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
      n_fail++; $display("FAIL reset_wins_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
    end
`endif
  endtask

  task automatic test_wrap();
    if_pc = 32'hFFFF_FFFC;
    set_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    n_checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap_redirect got=%b/%h exp=1/00000000", mispredict, redirect_pc);
    end
    n_checks++;
    if (pred_target !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pred_target got=%h exp=00000000", pred_target);
    end
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    int sel = $urandom_range(0, 19);
    int t;
    if (sel == 0) return 32'hFFFF_FFFC;
    t = (sel < 8) ? 0 : ((sel < 14) ? 1 : 5);
    return 32'((t << (IDX_W + 2)) | ($urandom_range(0, 7) << 2));
  endfunction

  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      if_valid = ($urandom_range(0, 7) != 0);
      if_pc    = rand_pc();
      pc       = rand_pc();
      set_ex($urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0, pc, 1'($urandom_range(0, 1)),
             rand_pc(), 1'b0, 32'h0);
      if ($urandom_range(0, 9) < 7) begin
        ex_pred_taken  = exp_taken(1'b1, pc);
        ex_pred_target = exp_target(1'b1, pc);
      end else begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = rand_pc();
      end
      #1;
      n_checks++;
      if (pred_taken !== exp_taken(if_valid, if_pc) || pred_target !== exp_target(if_valid, if_pc)) begin
        n_fail++;
        $display("FAIL rand_lookup n=%0d pc=%h got=%b/%h exp=%b/%h", n, if_pc, pred_taken,
                 pred_target, exp_taken(if_valid, if_pc), exp_target(if_valid, if_pc));
      end
      n_checks++;
      if (mispredict !== exp_misp() || (exp_misp() && redirect_pc !== exp_redir())) begin
        n_fail++;
        $display("FAIL rand_misp n=%0d got=%b/%h exp=%b/%h", n, mispredict, redirect_pc,
                 exp_misp(), exp_redir());
      end
      tick();
    end
    rst_n = 1'b1;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
`ifdef BP_STATS_EN
    n_checks++;
    if (stat_branches !== m_sb || stat_mispredicts !== m_sm) begin
      n_fail++; $display("FAIL rand_stats got=%0d/%0d exp=%0d/%0d", stat_branches,
                         stat_mispredicts, m_sb, m_sm);
    end
`endif
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_train_taken();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_reset_update();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 3-stage RV32I pipeline. Fetch looks up the current PC and gets a same-cycle taken/target prediction. Execute reports each resolved conditional branch outcome, as computed by the branch unit, together with the prediction that travelled with the instruction. The block trains a direct-mapped table of 2-bit saturating counters with tags and targets, and raises the mispredict/redirect signal that flushes fetch.

## Interface
Parameters:
- ENTRIES, 64, table depth; power of two, ≥ 4; IDX_W = $clog2(ENTRIES)
- TAG_W, 8, tag width; requires IDX_W + TAG_W ≤ 30

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset (sampled on rising clk)
- if_valid  in  1  fetch lookup valid
- if_pc  in  32  fetch PC
- pred_taken  out  1  predicted taken (combinational from if_pc)
- pred_target  out  32  predicted next PC (combinational)
- ex_valid  in  1  execute-stage instruction valid
- ex_is_branch  in  1  instruction is a conditional branch (BEQ..BGEU)
- ex_pc  in  32  PC of execute instruction
- ex_taken  in  1  resolved outcome (branch unit take_branch)
- ex_target  in  32  resolved branch target
- ex_pred_taken  in  1  prediction carried from fetch
- ex_pred_target  in  32  predicted target carried from fetch
- mispredict  out  1  flush fetch and redirect (combinational)
- redirect_pc  out  32  correct next PC when mispredict=1
- stat_branches  out  32  resolved-branch count (only with BP_STATS_EN)
- stat_mispredicts  out  32  mispredict count (only with BP_STATS_EN)

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag, 2-bit ctr (SNT=0, WNT=1, WT=2, ST=3), target[31:0].
- Lookup: hit = if_valid & valid[idx] & tag match. pred_taken = hit & ctr[1]. pred_target = pred_taken ? target : if_pc+4. If if_valid=0: pred_taken=0 and pred_target=if_pc+4.
- Update is enabled when ex_valid & ex_is_branch:
  - On tag hit: ctr saturating ±1 (taken increments, stops at ST; not-taken decrements, stops at SNT). target←ex_target only when ex_taken.
  - On miss or invalid entry: allocate; valid←1, tag←ex tag, ctr←ex_taken ? WT : WNT, target←ex_target.
- Alias case: ex_valid & !ex_is_branch & ex_pred_taken. Clear valid of the entry indexed by ex_pc, whether or not the tag matches.
- mispredict = ex_valid & ((ex_is_branch & (ex_taken≠ex_pred_taken | (ex_taken & ex_target≠ex_pred_target))) | (!ex_is_branch & ex_pred_taken)).
- redirect_pc = (ex_is_branch & ex_taken) ? ex_target : ex_pc+4.
- All PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 = 0x0000_0000.

## Timing
- Lookup latency 0: combinational from if_pc and table state.
- Update becomes visible to lookups from the cycle after the ex edge.
- Same-index lookup and update in one cycle: the lookup sees pre-update contents. No bypass.
- mispredict and redirect_pc are combinational in the same cycle as ex_*. The pipeline flushes on the next edge.
- Reset (rst_n=0 at an edge): all valid←0, all ctr←WNT, stats←0.
  - While rst_n=0, lookups still evaluate combinationally against current state.
  - An update presented in a reset cycle is discarded; reset wins.
- Outputs after reset: pred_taken=0, pred_target=if_pc+4, mispredict/redirect_pc follow inputs, stats=0.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on every update-enabled cycle.
  - stat_mispredicts increments whenever mispredict=1.
  - Both saturate at 0xFFFF_FFFF.
- BP_STATS_EN undefined: both stat ports and their counters are absent. Predictor behaviour is unchanged.

## Structure
- rv32i_pkg: bp_ctr_t enum (BP_SNT, BP_WNT, BP_WT, BP_ST) and bp_entry_t packed struct {valid, tag, ctr, target}. TAG_W stays a module parameter; the struct uses the default width.
- Sub-module: bp_sat_counter. Combinational 2-bit next-state (ctr, taken → ctr_next), reused for every entry update.
- Table is a flop array, not a memory macro, because reset must clear it in one cycle.

## Test plan
- **Cold lookup:** reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104.
- **Train taken:** resolve a branch with ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0.
  - Same cycle → mispredict=1, redirect_pc=0x80.
  - Next cycle, lookup 0x100 → pred_taken=1, pred_target=0x80 (ctr=WT).
- **Saturation:** resolve 0x100 taken ×3 → ctr=ST. Resolve not-taken once → WT, lookup still taken. Resolve not-taken again → WNT, pred_taken=0.
- **Alias/tag conflict:** train 0x100 taken.
  - Lookup 0x100+ENTRIES*4 (same index, different tag) → pred_taken=0.
  - Resolve a non-branch at 0x100 with ex_pred_taken=1 → mispredict=1, redirect_pc=0x104, entry invalidated.
- **Same-cycle lookup/update and reset:**
  - Update and lookup 0x100 in one cycle → lookup returns the old value.
  - Assert rst_n=0 together with an update → next lookup misses, stats=0 (with BP_STATS_EN).
- **Wrap:** resolve ex_pc=0xFFFF_FFFC not-taken with ex_pred_taken=1 → redirect_pc=0x0000_0000.
